// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// shared single-port RAM with combinational read data.
// - One access per cycle; the granted port drives the RAM directly.
// - Responses are registered: rspN_valid pulses the cycle after port N's
//   accept, carrying the RAM word read at the accept edge.
// - Port 1 may lock the bus for read-modify-write sequences.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin contention
// resolution; otherwise port 1 has fixed priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0: instruction fetch
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_wr_en,
  input  logic [DATA_WIDTH-1:0] req0_wr_data,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rd_data,
  // port 1: data
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_wr_en,
  input  logic [DATA_WIDTH-1:0] req1_wr_data,
  input  logic                  req1_lock,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rd_data,
  // shared RAM
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     state_reg;
  logic [1:0] grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0: port 0 wins the next contention, 1: port 1 wins
  logic       prio_reg;
`endif

  // Grant decision: lock first, then single requester, then contention rule.
  // Each ready depends only on valids, lock state and priority, never on the
  // other port's ready.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (state_reg == ST_LOCKED) begin
        grant[1] = req1_valid;
      end else if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (prio_reg) grant[1] = 1'b1;
        else          grant[0] = 1'b1;
`else
        grant[1] = 1'b1;
`endif
      end else begin
        grant[0] = req0_valid;
        grant[1] = req1_valid;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // RAM mux: the granted port drives the RAM, idle cycles drive zeros.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    if (grant[0]) begin
      mem_addr    = req0_addr;
      mem_wr_en   = req0_wr_en;
      mem_wr_data = req0_wr_data;
    end else if (grant[1]) begin
      mem_addr    = req1_addr;
      mem_wr_en   = req1_wr_en;
      mem_wr_data = req1_wr_data;
    end
  end

  // Lock FSM: only a port 1 accept can change the lock, and its lock bit
  // decides whether the bus stays held after that access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_OPEN;
    end else begin
      case (state_reg)
        ST_OPEN:   if (grant[1] && req1_lock)  state_reg <= ST_LOCKED;
        ST_LOCKED: if (grant[1] && !req1_lock) state_reg <= ST_OPEN;
        default:   state_reg <= ST_OPEN;
      endcase
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: the port just served loses the next contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (grant[0]) begin
      prio_reg <= 1'b1;
    end else if (grant[1]) begin
      prio_reg <= 1'b0;
    end
  end
`endif

  // Per-port response registers; data holds until that port's next response.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] data_reg;

      // Capture the RAM word (pre-write content for writes) on accept.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= grant[gi];
          if (grant[gi]) data_reg <= mem_rd_data;
        end
      end
    end
  endgenerate

  assign rsp0_valid   = g_rsp[0].valid_reg;
  assign rsp0_rd_data = g_rsp[0].data_reg;
  assign rsp1_valid   = g_rsp[1].valid_reg;
  assign rsp1_rd_data = g_rsp[1].data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_wr_en;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wr_data;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rd_data;
  logic          req1_valid, req1_ready, req1_wr_en, req1_lock;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wr_data;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wr_en(req0_wr_en), .req0_wr_data(req0_wr_data),
    .rsp0_valid(rsp0_valid), .rsp0_rd_data(rsp0_rd_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wr_en(req1_wr_en), .req1_wr_data(req1_wr_data), .req1_lock(req1_lock),
    .rsp1_valid(rsp1_valid), .rsp1_rd_data(rsp1_rd_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // RAM environment: 64 words, combinational read, written at posedge.
  logic [DW-1:0] ram [64];
  logic          bench_init;
  assign mem_rd_data = ram[mem_addr[5:0]];

  always @(posedge clk) begin
    if (bench_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 | i;
    end else if (mem_wr_en) begin
      ram[mem_addr[5:0]] <= mem_wr_data;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  bit            m_locked;
  bit            m_prio;
  bit            m_rsp_v [2];
  logic [DW-1:0] m_rsp_d [2];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int last_g;
  int gseq [4];
  int exp_seq [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_prio   = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_rsp_v[p] = 1'b0;
      m_rsp_d[p] = '0;
    end
  endtask

  // Which port the rules say wins this cycle (-1: none).
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_locked) return req1_valid ? 1 : -1;
    if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return m_prio ? 1 : 0;
`else
      return 1;
`endif
    end
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // One clock cycle: entered just after a negedge with inputs applied.
  task automatic cycle();
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    #1;
    g = exp_grant();
    a = '0; d = '0; w = 1'b0;
    if (g == 0) begin a = req0_addr; w = req0_wr_en; d = req0_wr_data; end
    if (g == 1) begin a = req1_addr; w = req1_wr_en; d = req1_wr_data; end
    check("req0_ready", req0_ready, (g == 0));
    check("req1_ready", req1_ready, (g == 1));
    check("mem_addr", mem_addr, a);
    check("mem_wr_en", mem_wr_en, w);
    check("mem_wr_data", mem_wr_data, d);
    check("rsp0_valid", rsp0_valid, m_rsp_v[0]);
    check("rsp1_valid", rsp1_valid, m_rsp_v[1]);
    check("rsp0_rd_data", rsp0_rd_data, m_rsp_d[0]);
    check("rsp1_rd_data", rsp1_rd_data, m_rsp_d[1]);
    if (g >= 0)
      $display("t=%0t port%0d %s addr=%0h wdata=%h lock=%0d", $time, g,
               w ? "WR" : "RD", a, d, (g == 1) ? req1_lock : 1'b0);
    last_g = g;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rsp_v[0] = 1'b0;
      m_rsp_v[1] = 1'b0;
      if (g >= 0) begin
        m_rsp_v[g] = 1'b1;
        m_rsp_d[g] = ref_mem[a[5:0]];
        if (w) ref_mem[a[5:0]] = d;
        if (g == 1) m_locked = req1_lock;
        m_prio = (g == 0);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_addr = '0; req0_wr_en = 0; req0_wr_data = '0;
    req1_valid = 0; req1_addr = '0; req1_wr_en = 0; req1_wr_data = '0;
    req1_lock = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    bench_init = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA000_0000 | i;
    @(posedge clk);
    @(negedge clk);
    bench_init = 1'b0;
    model_reset();

    // Reset state: nothing granted, no responses.
    cycle();
    rst_n = 1'b1;

    // Read of a known word through port 0 with port 1 idle.
    req1_valid = 1; req1_addr = 32'h10; req1_wr_en = 1; req1_wr_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    req0_valid = 1; req0_addr = 32'h10;
    cycle();
    check("r35_grant", last_g, 0);
    req0_valid = 0;
    cycle();
    check("r35_rsp_data", rsp0_rd_data, 32'hDEADBEEF);

    // Contention straight after reset.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    req0_valid = 1; req0_addr = 0;
    req1_valid = 1; req1_addr = 32;
    for (int k = 0; k < 4; k++) begin
      cycle();
      gseq[k] = last_g;
      if (last_g == 0) req0_addr = req0_addr + 1;
      if (last_g == 1) req1_addr = req1_addr + 1;
    end
    for (int k = 0; k < 4; k++) check("r36_grant_seq", gseq[k], exp_seq[k]);
    idle_inputs();
    cycle();

    // Port 1 write returns old content; port 0 then reads the new word.
    req1_valid = 1; req1_addr = 4; req1_wr_en = 1; req1_wr_data = 32'h5A5A5A5A;
    cycle();
    check("r37_grant", last_g, 1);
    idle_inputs();
    req0_valid = 1; req0_addr = 4;
    cycle();
    check("r37_old_data", rsp1_rd_data, 32'hA000_0004);
    req0_valid = 0;
    cycle();
    check("r37_new_data", rsp0_rd_data, 32'h5A5A5A5A);

    // Locked read-modify-write starves port 0 until the unlocking write.
    req1_valid = 1; req1_addr = 8; req1_lock = 1;
    cycle();
    check("r38_lock_grant", last_g, 1);
    req1_valid = 0; req1_lock = 0;
    req0_valid = 1; req0_addr = 20;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("r38_starved", last_g, -1);
    end
    req1_valid = 1; req1_addr = 8; req1_wr_en = 1; req1_wr_data = 32'h0BAD_F00D;
    cycle();
    check("r38_unlock_grant", last_g, 1);
    req1_valid = 0; req1_wr_en = 0;
    cycle();
    check("r38_port0_after", last_g, 0);
    idle_inputs();
    cycle();

    // Reset while locked with a response due.
    req1_valid = 1; req1_addr = 12; req1_lock = 1;
    cycle();
    idle_inputs();
    req0_valid = 1; req0_addr = 13;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("r39_grant_after_reset", last_g, 0);
    check("r39_rsp1_data_cleared", rsp1_rd_data, 32'h0);
    idle_inputs();
    cycle();

    // Randomized traffic with held requests and occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(63) != 0);
      if (!req0_valid && $urandom_range(1) == 1) begin
        req0_valid = 1; req0_addr = $urandom_range(63);
        req0_wr_en = $urandom_range(1); req0_wr_data = $urandom;
      end
      if (!req1_valid && $urandom_range(1) == 1) begin
        req1_valid = 1; req1_addr = $urandom_range(63);
        req1_wr_en = $urandom_range(1); req1_wr_data = $urandom;
        req1_lock = ($urandom_range(3) == 0);
      end
      cycle();
      if (last_g == 0) req0_valid = 0;
      if (last_g == 1) req1_valid = 0;
    end
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
